// File: rtl/permute_feeder.sv
// Feeds words from an in-order FIFO into a 1-cycle registered lane permuter,
// tracking valid/mode alongside so out_valid/out_mode line up with its dout.
module permute_feeder #(
   parameter int SIZE  = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4*SIZE-1:0]          in_data,
   input  logic [1:0]                 in_mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [4*SIZE-1:0]          perm_din,
   output logic [1:0]                 perm_control,
   output logic                       out_valid,
   output logic [1:0]                 out_mode,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int W  = 4 * SIZE;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Handshakes: a word moves on a rising edge where valid and ready are both 1.
   // in_ready depends on registered occupancy only; out_ready low while
   // out_valid is high stalls the output side and replays H into the permuter.

   logic [W+1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;

   logic          p_valid;
   logic [W-1:0]  p_data;
   logic [1:0]    p_mode;
   logic [W-1:0]  h_data;
   logic [1:0]    h_mode;
   logic          out_valid_q;

   logic          stall;
   logic          push;
   logic          pop;

   assign in_ready = (count_q < FULL);

   always_comb begin
      stall = out_valid_q && !out_ready;
      push  = in_valid && in_ready;
      pop   = !stall && (count_q != '0);
   end

   assign perm_din     = stall ? h_data : p_data;
   assign perm_control = stall ? h_mode : p_mode;
   assign out_valid    = out_valid_q;
   assign out_mode     = h_mode;
   assign count        = count_q;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= {in_mode, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         p_valid     <= 1'b0;
         p_data      <= '0;
         p_mode      <= '0;
         h_data      <= '0;
         h_mode      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= AW'(wr_ptr + 1'b1);
         end
         if (pop) begin
            rd_ptr <= AW'(rd_ptr + 1'b1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         // P/H advance only when the current result is not being held.
         if (!stall) begin
            out_valid_q <= p_valid;
            h_data      <= p_data;
            h_mode      <= p_mode;
            if (count_q != '0) begin
               p_valid          <= 1'b1;
               {p_mode, p_data} <= mem[rd_ptr];
            end else begin
               p_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_permute_feeder.sv
// Bench for permute_feeder with a 4x4 lane permuter attached; a negedge
// monitor scores results against a lane-index reference model.
module tb_permute_feeder;

   localparam int SIZE  = 4;
   localparam int DEPTH = 4;
   localparam int W     = 4 * SIZE;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_data;
   logic [1:0]    in_mode;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  perm_din;
   logic [1:0]    perm_control;
   logic          out_valid;
   logic [1:0]    out_mode;
   logic          out_ready;
   logic [CW-1:0] count;
   logic [W-1:0]  dout;

   int errors = 0;
   int checks = 0;

   logic [W+1:0] exp_q[$];
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_dout;
   logic [1:0]   prev_mode;

   always #5 clk = ~clk;

   permute_feeder #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
      .perm_din(perm_din), .perm_control(perm_control),
      .out_valid(out_valid), .out_mode(out_mode), .out_ready(out_ready),
      .count(count)
   );

   // The 4x4 permuter: registers its inputs every cycle.
   always_ff @(posedge clk) begin
      case (perm_control)
         2'd0:    dout <= perm_din;
         2'd1:    dout <= {perm_din[11:8], perm_din[15:12], perm_din[3:0], perm_din[7:4]};
         2'd2:    dout <= {perm_din[7:0], perm_din[15:8]};
         default: dout <= {perm_din[3:0], perm_din[7:4], perm_din[11:8], perm_din[15:12]};
      endcase
   end

   // Reference: output lane i takes input lane (i xor mode).
   function automatic logic [W-1:0] model_perm(input logic [W-1:0] d, input logic [1:0] m);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*SIZE +: SIZE] = d[(i ^ int'(m))*SIZE +: SIZE];
      end
      return r;
   endfunction

   initial begin
      logic [W+1:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               checks++;
               if (out_valid !== 1'b1 || dout !== prev_dout || out_mode !== prev_mode) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%b dout=%h mode=%0d, required valid=1 dout=%h mode=%0d",
                           out_valid, dout, out_mode, prev_dout, prev_mode);
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back({in_mode, model_perm(in_data, in_mode)});
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: dout=%h mode=%0d, required no output", dout, out_mode);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_mode, dout} !== e) begin
                     errors++;
                     $display("FAIL output_order: mode=%0d dout=%h, required mode=%0d dout=%h",
                              out_mode, dout, e[W+1:W], e[W-1:0]);
                  end
               end
            end
            checks++;
            if (int'(count) > DEPTH || in_ready !== (int'(count) < DEPTH)) begin
               errors++;
               $display("FAIL occupancy: count=%0d in_ready=%b, required count<=%0d and in_ready=(count<%0d)",
                        count, in_ready, DEPTH, DEPTH);
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_mode  = out_mode;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] d, input logic [1:0] m);
      int n;
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (n == 20) begin
         errors++;
         $display("FAIL push_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks += 6;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
      if (count !== '0) begin errors++; $display("FAIL reset_count: %0d, required 0", count); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
      if (perm_din !== '0) begin errors++; $display("FAIL reset_perm_din: %h, required 0", perm_din); end
      if (perm_control !== '0) begin errors++; $display("FAIL reset_perm_control: %0d, required 0", perm_control); end
      if (out_mode !== '0) begin errors++; $display("FAIL reset_out_mode: %0d, required 0", out_mode); end
   endtask

   task automatic test_single();
      logic [W-1:0] tbl [4];
      tbl = '{16'h4321, 16'h3412, 16'h2143, 16'h1234};
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         step();
         in_data = 16'h4321; in_mode = 2'(m); in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready m=%0d: %b, required 1", m, in_ready); end
         step();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 m=%0d: out_valid=%b, required 0", m, out_valid); end
         step();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat2 m=%0d: out_valid=%b, required 0", m, out_valid); end
         step();
         checks++;
         if (out_valid !== 1'b1 || dout !== tbl[m] || out_mode !== 2'(m)) begin
            errors++;
            $display("FAIL single_result m=%0d: valid=%b dout=%h mode=%0d, required valid=1 dout=%h mode=%0d",
                     m, out_valid, dout, out_mode, tbl[m], m);
         end
         step();
      end
   endtask

   task automatic test_stream();
      int rises, ov_cycles, max_count;
      logic prev_ov;
      rises = 0; ov_cycles = 0; max_count = 0; prev_ov = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 8) begin
            in_valid = 1'b1; in_data = W'(16'h1111 * (i + 1)); in_mode = 2'd0;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (int'(count) > max_count) max_count = int'(count);
         if (out_valid && !prev_ov) rises++;
         if (out_valid) ov_cycles++;
         prev_ov = out_valid;
      end
      checks += 3;
      if (max_count > 1) begin errors++; $display("FAIL stream_count: max=%0d, required <=1", max_count); end
      if (ov_cycles != 8) begin errors++; $display("FAIL stream_valid_cycles: %0d, required 8", ov_cycles); end
      if (rises != 1) begin errors++; $display("FAIL stream_contiguous: %0d bursts, required 1", rises); end
      wait_drain("stream");
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w0;
      logic [1:0]   m0;
      out_ready = 1'b0;
      w0 = W'($urandom);
      m0 = 2'($urandom_range(0, 3));
      push_word(w0, m0);
      for (int i = 1; i < 6; i++) push_word(W'($urandom), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 3; i++) step();
      checks += 3;
      if (count !== CW'(DEPTH)) begin errors++; $display("FAIL bp_count: %0d, required %0d", count, DEPTH); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: %b, required 0", in_ready); end
      if (out_valid !== 1'b1 || dout !== model_perm(w0, m0) || out_mode !== m0) begin
         errors++;
         $display("FAIL bp_hold: valid=%b dout=%h mode=%0d, required valid=1 dout=%h mode=%0d",
                  out_valid, dout, out_mode, model_perm(w0, m0), m0);
      end
      out_ready = 1'b1;
      wait_drain("bp");
   endtask

   task automatic test_wrap();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(W'($urandom), 2'($urandom_range(0, 3)));
      checks += 2;
      if (count !== 3'd3) begin errors++; $display("FAIL wrap_fill: count=%0d, required 3", count); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: %b, required 1", out_valid); end
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = W'($urandom); in_mode = 2'($urandom_range(0, 3));
         step();
         checks++;
         if (count !== 3'd3) begin errors++; $display("FAIL wrap_pushpop i=%0d: count=%0d, required 3", i, count); end
      end
      in_valid = 1'b0;
      wait_drain("wrap");
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(W'($urandom), 2'($urandom_range(0, 3)));
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: %b, required 1", out_valid); end
      if (count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: %0d, required 3", count); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: %b, required 0", out_valid); end
      if (count !== '0) begin errors++; $display("FAIL rmid_count: %0d, required 0", count); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: %b, required 1", in_ready); end
      if (perm_din !== '0) begin errors++; $display("FAIL rmid_perm_din: %h, required 0", perm_din); end
      out_ready = 1'b1;
      in_data = 16'hA5A5; in_mode = 2'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1 || dout !== 16'h5A5A || out_mode !== 2'd3) begin
         errors++;
         $display("FAIL rmid_result: valid=%b dout=%h mode=%0d, required valid=1 dout=5a5a mode=3",
                  out_valid, dout, out_mode);
      end
      step();
      wait_drain("rmid");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: %0d words lost, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/permute_feeder.md
PERMUTE_FEEDER -- requirements
Module: permute_feeder

Interface
REQ-001 Parameter SIZE, default 4: lane width in bits; four lanes per word.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_data  input  4*SIZE  word to be permuted; lane i = bits [(i+1)*SIZE-1 : i*SIZE].
REQ-006 in_mode  input  2  permutation select carried with the word.
REQ-007 in_valid  input  1  upstream offers in_data/in_mode.
REQ-008 in_ready  output  1  feeder accepts this cycle.
REQ-009 perm_din  output  4*SIZE  drives the permuter's din.
REQ-010 perm_control  output  2  drives the permuter's control.
REQ-011 out_valid  output  1  the permuter's registered dout holds a valid result.
REQ-012 out_mode  output  2  mode of the word whose result is in dout.
REQ-013 out_ready  input  1  downstream consumes dout this cycle.
REQ-014 count  output  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-015 The permuter registers perm_din/perm_control unconditionally every cycle with 1-cycle latency; the feeder SHALL align out_valid to that latency.
REQ-016 Storage: an in-order FIFO of {data, mode}, a present register P {valid, data, mode}, and a hold register H {data, mode} for the word whose result is in dout.
REQ-017 in_ready SHALL be 1 iff count < DEPTH, from registered state only. Push occurs when in_valid && in_ready.
REQ-018 stall = out_valid && !out_ready; this is the only combinational input-to-output path.
REQ-019 perm_din/perm_control SHALL equal H when stall=1 and P otherwise. P.data/P.mode SHALL be driven even when P.valid=0.
REQ-020 When stall=0, the following SHALL happen at the edge:
- out_valid <= P.valid;
- H <= P;
- P <= FIFO head with valid=1 and a pop, if count > 0; otherwise P.valid <= 0 and P.data/P.mode hold.
REQ-021 When stall=1, the following SHALL hold their values: P, H, out_valid and the FIFO read side. Pushes still proceed.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged. At count = DEPTH no push occurs; count SHALL never exceed DEPTH or underflow.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 Words SHALL emerge in acceptance order, with no loss or duplication.
REQ-025 out_mode SHALL equal H.mode.
REQ-026 Latency: a word pushed at edge k into an empty feeder (count=0, P.valid=0, no stall):
- enters P at edge k+1;
- its result is in dout with out_valid=1 after edge k+2.
REQ-027 Throughput: sustained 1 word per cycle while in_valid=1 and out_ready=1.
REQ-028 During a stall, dout SHALL remain bit-stable, because H is replayed into the permuter.
REQ-029 All 4 mode encodings are legal. The feeder SHALL NOT inspect or alter data.

Reset
REQ-030 With rst=1 at an edge, the following SHALL be cleared: count=0, FIFO pointers=0, P={0,0,0}, H=0, out_valid=0.
REQ-031 The combinational outputs SHALL then be: perm_din=0, perm_control=0, out_mode=0, in_ready=1.
REQ-032 rst SHALL take priority over push, pop and stall. A reset mid-operation discards all buffered and in-flight words.
REQ-033 The first push is accepted at the first edge with rst=0.

Verification
The bench instantiates permute_feeder driving the 4x4 permuter with SIZE=4. All values below are hex.

REQ-034 Single word: in_data=4321, in_mode=0,1,2,3 (one at a time, idle between) -> out_valid exactly 2 edges after acceptance; dout = 4321, 3412, 2143, 1234 respectively; out_mode matches.
REQ-035 Streaming: 8 back-to-back words 1111..8888 with mode=0 and out_ready=1 -> 8 consecutive out_valid cycles in order; count never exceeds 1.
REQ-036 Backpressure and full: out_ready=0 while pushing 6 words ->
- stall holds dout = 1st result;
- count reaches 4 and in_ready falls;
- releasing out_ready drains all 6 in order with no duplicates.
REQ-037 Simultaneous push/pop at count=DEPTH-1 -> count holds 3; FIFO pointer wrap is exercised over more than 2*DEPTH words with no data error.
REQ-038 Reset mid-stream: rst=1 for 1 cycle with 3 words buffered and out_valid=1 ->
- next cycle: out_valid=0, count=0, in_ready=1, perm_din=0;
- pre-reset words never appear;
- the next pushed word A5A5 with mode=3 emerges as 5A5A.
